seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
- Time-multiplexed 4-digit seven-segment driver, directly downstream of the binary-to-BCD converter.
- Consumes Ones/Tens/Hundreds BCD digits plus a sign flag for the multiplier result, and holds them in a shadow register.
- Commits the shadow register only at frame boundaries, so the display never tears.
- Scans the digits onto a common-anode display with optional leading-zero blanking.

Parameters:
- CLK_DIV, 50000, clock cycles per digit slot (prescaler period); legal range >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bcd_valid  input  1  single-cycle strobe; capture ones/tens/hundreds/neg into the shadow register.
- ones  input  4  BCD ones digit.
- tens  input  4  BCD tens digit.
- hundreds  input  4  BCD hundreds digit.
- neg  input  1  result is negative; show '-' on the sign digit.
- blank_lz  input  1  leading-zero blanking enable; static config, sampled live.
- seg  output  7  segments {g,f,e,d,c,b,a}, active low, registered.
- an  output  4  digit anodes, active low, one-hot-low, registered.
- frame_done  output  1  one-cycle pulse when the sign slot ends (digit index wraps 3->0).

Behaviour:
- Reset is asynchronous and active-low; one clock. While rst_n=0:
  - prescaler=0, idx=0
  - shadow and display registers = 0, pending=0
  - an=4'b1111, seg=7'b1111111, frame_done=0
- Reset mid-scan takes effect immediately, without waiting for a clock edge. After release, scanning restarts at idx 0.
- Prescaler counts 0..CLK_DIV-1. tick=1 when count==CLK_DIV-1, and the counter then returns to 0. With CLK_DIV=1, tick=1 every cycle.
- On tick, idx advances 0->1->2->3->0.
- Slot mapping:
  - idx0 = ones, an[0]
  - idx1 = tens, an[1]
  - idx2 = hundreds, an[2]
  - idx3 = sign, an[3]
- Load: on bcd_valid=1, shadow <= {neg,hundreds,tens,ones} and pending <= 1. A later bcd_valid before commit overwrites the shadow register (last write wins).
- Commit: on a tick with idx==3, if pending, display <= shadow and pending <= 0.
  - frame_done=1 for that one cycle, whether or not a commit happens.
- Simultaneous load and commit on the same edge:
  - The commit uses the shadow value from before this edge.
  - The new data loads into the shadow register and pending stays 1.
  - The new data is committed at the next frame boundary.
- Output latency: seg and an are registered from the current idx and display registers. A digit appears one cycle after idx changes, and each digit is held for CLK_DIV cycles.
- Decode (active low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - any value 10..15 displays 'E'=0000110
  - blank=1111111
  - '-'=0111111
- Sign slot: '-' if display.neg=1, otherwise blank.
- Leading-zero blanking (blank_lz=1):
  - Hundreds is blanked if it equals 0.
  - Tens is blanked if hundreds==0 and tens==0.
  - Ones is never blanked.
  - A non-BCD digit is never blanked; it shows 'E'.
  - With blank_lz=0, all numeric digits are shown.
- Digits wider than BCD range are not clamped; they decode to 'E' as listed above.

Decomposition:
- Shared package:
  - SEG_BLANK, SEG_MINUS and SEG_E constants
  - the 0-9 segment table
  - the slot index typedef, 2 bits, with enum ONES/TENS/HUNDREDS/SIGN
- One sub-module: seg7_decode, purely combinational. Inputs: 4-bit digit and blank flag. Output: 7-bit active-low segments. It is reused by the top for every slot, with the sign slot selected by a mux.

Test Plan:
All scenarios use CLK_DIV=4.
1. Reset: assert rst_n=0 mid-slot with no clock edge -> an=1111 and seg=1111111 immediately. After release, the first active slot is an=1110.
2. Load 255 (ones=5, tens=5, hundreds=2, neg=0, blank_lz=0) -> after the next frame_done, the scan shows 1110/0010010, 1101/0010010, 1011/0100100, 0111/1111111, with each pair held 4 cycles.
3. Load 7 with neg=1:
   - blank_lz=1 -> ones=1111000, tens blank, hundreds blank, sign=0111111.
   - Switching to blank_lz=0 -> tens and hundreds show 1000000.
4. Tear-free update: pulse bcd_valid with 128 while idx=1 showing 255 -> slots keep showing 255 until the idx3 tick. The first frame after frame_done shows 8/2/1.
5. Invalid digit: tens=4'hC -> the tens slot shows 0000110, and blank_lz=1 does not blank it.
6. Load/commit collision: bcd_valid carrying 99 on the same cycle as the idx3 tick with 42 pending -> the next frame shows 42, and the frame after that shows 99.

Source files
------------

// File: rtl/seven_seg_scanner_pkg.sv
// Shared segment encodings, slot indices and BCD word layout for the seven-segment scanner.
// All segment patterns are active low, ordered {g,f,e,d,c,b,a}.
package seven_seg_scanner_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    typedef enum logic [1:0] {
        ONES     = 2'd0,
        TENS     = 2'd1,
        HUNDREDS = 2'd2,
        SIGN     = 2'd3
    } slot_t;

    typedef struct packed {
        logic       neg;
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_word_t;

    // 0-9 segment table; anything outside BCD range shows 'E'.
    function automatic logic [6:0] seg_table(input logic [3:0] digit);
        logic [6:0] s;
        case (digit)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-to-segment decoder with a blank override.
// Output is active low, {g,f,e,d,c,b,a}.
module seg7_decode (
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);
    import seven_seg_scanner_pkg::*;

    always_comb begin
        seg = blank ? SEG_BLANK : seg_table(digit);
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit common-anode scanner with a shadow register that is
// committed only at frame boundaries, plus optional leading-zero blanking.
module seven_seg_scanner #(
    parameter int unsigned CLK_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bcd_valid,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic       neg,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_done
);
    import seven_seg_scanner_pkg::*;

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    slot_t         idx_q;
    bcd_word_t     shadow_q;
    bcd_word_t     disp_q;
    logic          pending_q;
    logic [6:0]    seg_q;
    logic [3:0]    an_q;

    logic          tick;
    logic          frame_end;
    logic [3:0]    digit;
    logic          blank;
    logic [6:0]    dec_seg;
    logic [6:0]    seg_d;
    logic [3:0]    an_d;

    assign tick      = (cnt_q == CNT_MAX);
    assign frame_end = tick && (idx_q == SIGN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= ONES;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
                idx_q <= slot_t'(idx_q + 2'd1);
            end
        end
    end

    // A load coinciding with a commit wins pending, so the fresh data goes out next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            if (bcd_valid) begin
                shadow_q <= {neg, hundreds, tens, ones};
            end
            if (frame_end && pending_q) begin
                disp_q <= shadow_q;
            end
            if (bcd_valid) begin
                pending_q <= 1'b1;
            end else if (frame_end) begin
                pending_q <= 1'b0;
            end
        end
    end

    always_comb begin
        digit = 4'd0;
        blank = 1'b0;
        unique case (idx_q)
            ONES: begin
                digit = disp_q.ones;
            end
            TENS: begin
                digit = disp_q.tens;
                blank = blank_lz && (disp_q.hundreds == 4'd0) && (disp_q.tens == 4'd0);
            end
            HUNDREDS: begin
                digit = disp_q.hundreds;
                blank = blank_lz && (disp_q.hundreds == 4'd0);
            end
            SIGN: begin
                blank = 1'b1;
            end
        endcase
    end

    seg7_decode u_decode (
        .digit (digit),
        .blank (blank),
        .seg   (dec_seg)
    );

    always_comb begin
        seg_d = dec_seg;
        if (idx_q == SIGN) begin
            seg_d = disp_q.neg ? SEG_MINUS : SEG_BLANK;
        end
        an_d = ~(4'b0001 << idx_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= SEG_BLANK;
            an_q  <= 4'b1111;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_end;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed self-checking bench for seven_seg_scanner at CLK_DIV=4.
// Outputs are sampled on the falling clock edge.
module tb_seven_seg_scanner;

    localparam int unsigned CLK_DIV = 4;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] MI = 7'b0111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bcd_valid = 1'b0;
    logic [3:0] ones = 4'd0;
    logic [3:0] tens = 4'd0;
    logic [3:0] hundreds = 4'd0;
    logic       neg = 1'b0;
    logic       blank_lz = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    seven_seg_scanner #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_valid  (bcd_valid),
        .ones       (ones),
        .tens       (tens),
        .hundreds   (hundreds),
        .neg        (neg),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One-cycle load strobe; returns one falling edge later.
    task automatic pulse(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                         input logic n);
        hundreds  = h;
        tens      = t;
        ones      = o;
        neg       = n;
        bcd_valid = 1'b1;
        @(negedge clk);
        bcd_valid = 1'b0;
    endtask

    task automatic wait_fd();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (frame_done) break;
        end
        chk("fd_wait", {6'b0, frame_done}, 7'd1);
    endtask

    // Position k counts falling edges from the first ones-slot cycle; k=14 is the next frame_done.
    task automatic check_slots(input string tag, input int kfirst, input logic [6:0] s0,
                               input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3);
        for (int k = kfirst; k <= 14; k++) begin
            logic [6:0] es;
            logic [3:0] ea;
            case (k / 4)
                0:       begin es = s0; ea = 4'b1110; end
                1:       begin es = s1; ea = 4'b1101; end
                2:       begin es = s2; ea = 4'b1011; end
                default: begin es = s3; ea = 4'b0111; end
            endcase
            chk($sformatf("%s_an_k%0d", tag, k), {3'b0, an}, {3'b0, ea});
            chk($sformatf("%s_seg_k%0d", tag, k), seg, es);
            chk($sformatf("%s_fd_k%0d", tag, k), {6'b0, frame_done}, (k == 14) ? 7'd1 : 7'd0);
            if (k < 14) @(negedge clk);
        end
    endtask

    // Entered on the falling edge where frame_done is high; checks the frame committed there.
    task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3);
        chk({tag, "_fd_entry"}, {6'b0, frame_done}, 7'd1);
        @(negedge clk);
        @(negedge clk);
        check_slots(tag, 0, s0, s1, s2, s3);
    endtask

    initial begin
        // 1. Reset values, then asynchronous reset mid-scan.
        repeat (3) @(negedge clk);
        chk("rst_an", {3'b0, an}, {3'b0, 4'b1111});
        chk("rst_seg", seg, BL);
        chk("rst_fd", {6'b0, frame_done}, 7'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_an", {3'b0, an}, {3'b0, 4'b1110});
        chk("rel_seg", seg, S0);
        pulse(4'd9, 4'd9, 4'd9, 1'b0);
        repeat (4) @(negedge clk);
        chk("pre_rst_an", {3'b0, an}, {3'b0, 4'b1101});
        chk("pre_rst_seg", seg, S0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_an", {3'b0, an}, {3'b0, 4'b1111});
        chk("async_rst_seg", seg, BL);
        chk("async_rst_fd", {6'b0, frame_done}, 7'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel2_an", {3'b0, an}, {3'b0, 4'b1110});
        chk("rel2_seg", seg, S0);
        // Pending 999 was dropped by reset, so the display stays at zero.
        wait_fd();
        check_frame("zero", S0, S0, S0, BL);

        // 2. 255, no blanking.
        blank_lz = 1'b0;
        pulse(4'd2, 4'd5, 4'd5, 1'b0);
        wait_fd();
        check_frame("v255", S5, S5, S2, BL);

        // 3. -7 with and without leading-zero blanking.
        blank_lz = 1'b1;
        pulse(4'd0, 4'd0, 4'd7, 1'b1);
        wait_fd();
        check_frame("m7_lz", S7, BL, BL, MI);
        blank_lz = 1'b0;
        check_frame("m7", S7, S0, S0, MI);

        // 4. Load 128 mid-frame while 255 is on display; no tearing.
        pulse(4'd2, 4'd5, 4'd5, 1'b0);
        wait_fd();
        check_frame("v255b", S5, S5, S2, BL);
        repeat (6) @(negedge clk);
        pulse(4'd1, 4'd2, 4'd8, 1'b0);
        check_slots("tear", 5, S5, S5, S2, BL);
        check_frame("v128", S8, S2, S1, BL);

        // 5. Non-BCD tens digit is shown as E and never blanked.
        blank_lz = 1'b1;
        pulse(4'd0, 4'hC, 4'd3, 1'b0);
        wait_fd();
        check_frame("bad_tens", S3, SE, BL, BL);

        // 6. Load of 99 on the same edge that commits pending 42.
        blank_lz = 1'b0;
        @(negedge clk);
        pulse(4'd0, 4'd4, 4'd2, 1'b0);
        wait_fd();
        hundreds  = 4'd0;
        tens      = 4'd9;
        ones      = 4'd9;
        neg       = 1'b0;
        bcd_valid = 1'b1;
        chk("col_fd", {6'b0, frame_done}, 7'd1);
        @(negedge clk);
        bcd_valid = 1'b0;
        @(negedge clk);
        check_slots("col42", 0, S2, S4, S0, BL);
        check_frame("col99", S9, S9, S0, BL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
